// File: rtl/sram_pkg.sv
// Shared types and constants for the synchronous single-port SRAM.
package sram_pkg;

    // Clear-sequencer states: sweeping the array to zero, or serving requests.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_t;

    // Replicated to DATA_W bits wherever the read register is forced idle.
    localparam bit RD_DATA_RST = 1'b0;

endpackage

// File: rtl/sram_clear_seq.sv
// Self-timed whole-array clear sequencer: walks clr_ptr across every word
// after reset or on clr_req, holding busy high until the last word is zeroed.
module sram_clear_seq #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);
    import sram_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    sram_state_t       state;
    logic [ADDR_W-1:0] clr_ptr;

    // State, sweep pointer and busy flag advance together on each clock.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    // The pointer wraps to zero on the same edge that exits.
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_PTR) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    // While reset is held the array must not be written, so gate the sweep.
    assign clr_we   = reset && (state == CLEAR);
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/sram_sync_array.sv
// Parametrised synchronous single-port SRAM with a registered read path,
// a one-cycle rd_valid strobe and a self-timed whole-array clear.
module sram_sync_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);
    import sram_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    sram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    // A clear request wins over a write issued in the same cycle.
    assign user_we   = reset && !busy && wr_en && !clr_req;
    assign mem_we    = clr_we || user_we;
    assign mem_addr  = clr_we ? clr_addr : addr;
    assign mem_wdata = clr_we ? '0 : wr_data;

    // Single write port shared between the clear sweep and the user.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset term; it is zeroed by the clear sweep,
        // which keeps it mappable onto a plain RAM macro.
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Registered read: data and valid appear one cycle after rd_en, and the
    // old word is returned when a write to the same address shares the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data  <= {DATA_W{RD_DATA_RST}};
            rd_valid <= 1'b0;
        end else if (rd_en && !busy) begin
            rd_data  <= mem[addr];
            rd_valid <= 1'b1;
        end else begin
            rd_data  <= {DATA_W{RD_DATA_RST}};
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_sync_array.sv
// Self-checking bench: drives a default (8x4) and a wide (16x16) instance
// from one stimulus bus and compares both against a word-array model.
module tb_sram_sync_array;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic        rd_en;
    logic        clr_req;
    logic [3:0]  addr;
    logic [15:0] wr_data;

    logic [7:0]  a_rd_data;
    logic        a_rd_valid;
    logic        a_busy;
    logic [15:0] b_rd_data;
    logic        b_rd_valid;
    logic        b_busy;

    int checks   = 0;
    int failures = 0;

    sram_sync_array #(.DATA_W(8), .ADDR_W(2)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr[1:0]),
        .wr_data  (wr_data[7:0]),
        .clr_req  (clr_req),
        .rd_data  (a_rd_data),
        .rd_valid (a_rd_valid),
        .busy     (a_busy)
    );

    sram_sync_array #(.DATA_W(16), .ADDR_W(4)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .rd_data  (b_rd_data),
        .rd_valid (b_rd_valid),
        .busy     (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: index 0 is the 4-word instance, index 1 the 16-word one.
    int          depth [2];
    logic [15:0] dmask [2];
    logic [15:0] m_mem [2][16];
    int          m_left [2];
    int          m_idx [2];
    logic [15:0] m_rd [2];
    logic        m_val [2];
    int          cyc = 0;

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int a;
            a = int'(addr) % depth[i];
            if (!reset) begin
                m_left[i] = depth[i];
                m_idx[i]  = 0;
                m_rd[i]   = 16'h0;
                m_val[i]  = 1'b0;
            end else if (m_left[i] > 0) begin
                m_mem[i][m_idx[i]] = 16'h0;
                m_idx[i]  = m_idx[i] + 1;
                m_left[i] = m_left[i] - 1;
                m_rd[i]   = 16'h0;
                m_val[i]  = 1'b0;
            end else begin
                if (rd_en) begin
                    m_rd[i]  = m_mem[i][a];
                    m_val[i] = 1'b1;
                end else begin
                    m_rd[i]  = 16'h0;
                    m_val[i] = 1'b0;
                end
                if (clr_req) begin
                    m_left[i] = depth[i];
                    m_idx[i]  = 0;
                end else if (wr_en) begin
                    m_mem[i][a] = wr_data & dmask[i];
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model at the edge, compare both instances after it.
    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check($sformatf("a_busy@%0d", cyc),   {15'h0, a_busy},     {15'h0, m_left[0] > 0});
        check($sformatf("a_valid@%0d", cyc),  {15'h0, a_rd_valid}, {15'h0, m_val[0]});
        check($sformatf("a_data@%0d", cyc),   {8'h0, a_rd_data},   m_rd[0]);
        check($sformatf("b_busy@%0d", cyc),   {15'h0, b_busy},     {15'h0, m_left[1] > 0});
        check($sformatf("b_valid@%0d", cyc),  {15'h0, b_rd_valid}, {15'h0, m_val[1]});
        check($sformatf("b_data@%0d", cyc),   b_rd_data,           m_rd[1]);
    endtask

    task automatic drive(input logic we, input logic re, input logic cr,
                         input logic [3:0] a, input logic [15:0] d);
        wr_en   = we;
        rd_en   = re;
        clr_req = cr;
        addr    = a;
        wr_data = d;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 40 && (a_busy || b_busy); i++) cycle();
        check(tag, {14'h0, a_busy, b_busy}, 16'h0);
    endtask

    initial begin
        int n;
        depth[0] = 4;  dmask[0] = 16'h00FF;
        depth[1] = 16; dmask[1] = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 16; j++) m_mem[i][j] = 'x;
            m_left[i] = 0; m_idx[i] = 0; m_rd[i] = 16'h0; m_val[i] = 1'b0;
        end

        // 1. Reset low three cycles, then count the sweep lengths.
        reset = 1'b0;
        drive(0, 0, 0, 4'd0, 16'h0);
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        n = 0;
        while (a_busy && n < 40) begin cycle(); n++; end
        check("a_sweep_len", 16'(n), 16'd4);
        while (b_busy && n < 40) begin cycle(); n++; end
        check("b_sweep_len", 16'(n), 16'd16);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 4'(i), 16'h0);
            cycle();
        end

        // 2. Two writes, then back-to-back reads, then idle.
        drive(1, 0, 0, 4'd1, 16'h12A5); cycle();
        drive(1, 0, 0, 4'd3, 16'h343C); cycle();
        drive(0, 1, 0, 4'd3, 16'h0);    cycle();
        drive(0, 1, 0, 4'd1, 16'h0);    cycle();
        check("a_b2b_second", {8'h0, a_rd_data}, 16'h00A5);
        drive(0, 0, 0, 4'd0, 16'h0);    cycle();

        // 3. Read-before-write on the same address.
        drive(1, 0, 0, 4'd2, 16'h0011); cycle();
        drive(1, 1, 0, 4'd2, 16'h0077); cycle();
        check("a_rbw_old", {8'h0, a_rd_data}, 16'h0011);
        drive(0, 1, 0, 4'd2, 16'h0);    cycle();
        check("a_rbw_new", {8'h0, a_rd_data}, 16'h0077);

        // 4. Clear request with a competing write and a served read.
        drive(1, 1, 1, 4'd0, 16'h00FF); cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 4'(i), 16'hFFFF);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 4'(i), 16'h0);
            cycle();
        end

        // 5. Reset pulse mid-sweep when clr_ptr has reached 2.
        wait_ready("ready_before_pulse");
        drive(1, 0, 0, 4'd1, 16'h5A5A); cycle();
        drive(0, 0, 1, 4'd0, 16'h0);    cycle();
        drive(0, 0, 0, 4'd0, 16'h0);
        cycle();
        cycle();
        reset = 1'b0; cycle();
        reset = 1'b1;
        n = 0;
        while (a_busy && n < 40) begin cycle(); n++; end
        check("a_restart_len", 16'(n), 16'd4);

        // 6. Wide instance: top address write/readback, address 0 still zero.
        wait_ready("ready_before_wide");
        drive(1, 0, 0, 4'd15, 16'hBEEF); cycle();
        drive(0, 1, 0, 4'd15, 16'h0);    cycle();
        check("b_addr15", b_rd_data, 16'hBEEF);
        drive(0, 1, 0, 4'd0, 16'h0);     cycle();
        check("b_addr0", b_rd_data, 16'h0000);

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            drive(1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0),
                  4'($urandom), 16'($urandom));
            cycle();
        end
        reset = 1'b1;
        drive(0, 0, 0, 4'd0, 16'h0);
        wait_ready("ready_at_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
